// File: rtl/iter_div.sv
// Radix-2 restoring integer divider, signed/unsigned, with valid/ready
// handshakes on both sides, flush cancel, and fixed WIDTH+1 cycle latency.
module iter_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               dvd_neg, dsr_neg;
  logic [WIDTH:0]     shift;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  assign in_ready = !reset && !flush &&
                    ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign dvd_neg  = in_signed && dividend[WIDTH-1];
  assign dsr_neg  = in_signed && divisor[WIDTH-1];

  // The trial subtract is two bits wider than the divisor so its sign bit is
  // reliable even when the shifted partial remainder uses bit WIDTH.
  assign shift    = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = {1'b0, shift} - {2'b00, dsr_q};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_step = q_bit ? trial[WIDTH-1:0] : shift[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    raw_d       = raw_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div0_d      = div0_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          dvd_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            quo_d       = div0_q ? '1 : (q_neg_q ? -quo_step : quo_step);
            rmd_d       = div0_q ? raw_q : (r_neg_q ? -rem_step : rem_step);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase

      // A load from IDLE or from a consumed DONE overrides the above.
      if (accept) begin
        state_d     = S_CALC;
        out_valid_d = 1'b0;
        cnt_d       = CNT_W'(WIDTH - 1);
        dvd_d       = dvd_neg ? -dividend : dividend;
        dsr_d       = dsr_neg ? -divisor : divisor;
        rem_d       = '0;
        raw_d       = dividend;
        q_neg_d     = dvd_neg ^ dsr_neg;
        r_neg_d     = dvd_neg;
        div0_d      = (divisor == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      raw_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      raw_q       <= raw_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      div0_q      <= div0_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign busy      = (state_q != S_IDLE);

endmodule
